// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: diff = a - b, one bit per clock, start/done handshake.
// Define SERIAL_SUB_OVERFLOW_EN to add a registered signed-overflow output.
//
// state | meaning
// IDLE  | waiting for start; operands captured on the accepting edge
// RUN   | one bit processed per edge through the full-subtractor cell
// DONE  | one-cycle done pulse; returns to IDLE unconditionally
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVERFLOW_EN
    output logic             overflow,
`endif
    output logic             borrow
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sa_q, sa_d;
    logic [WIDTH-1:0]   sb_q, sb_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               bf_q, bf_d;
    logic               borrow_q, borrow_d;
    logic               cell_d, cell_bout;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic               a_msb_q, a_msb_d;
    logic               b_msb_q, b_msb_d;
    logic               overflow_q, overflow_d;
`endif

    // Full-subtractor bit cell on the current LSBs and the registered borrow.
    always_comb begin
        cell_d    = sa_q[0] ^ sb_q[0] ^ bf_q;
        cell_bout = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & bf_q);
    end

    always_comb begin
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        res_d    = res_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        bf_d     = bf_q;
        borrow_d = borrow_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
        a_msb_d    = a_msb_q;
        b_msb_d    = b_msb_q;
        overflow_d = overflow_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    bf_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
`ifdef SERIAL_SUB_OVERFLOW_EN
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
`endif
                end
            end
            RUN: begin
                bf_d  = cell_bout;
                res_d = {cell_d, res_q[WIDTH-1:1]};
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    diff_d   = {cell_d, res_q[WIDTH-1:1]};
                    borrow_d = cell_bout;
                    state_d  = DONE;
`ifdef SERIAL_SUB_OVERFLOW_EN
                    overflow_d = (a_msb_q != b_msb_q) && (cell_d != a_msb_q);
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            bf_q     <= 1'b0;
            borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
            a_msb_q    <= 1'b0;
            b_msb_q    <= 1'b0;
            overflow_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            res_q    <= res_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            bf_q     <= bf_d;
            borrow_q <= borrow_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
            a_msb_q    <= a_msb_d;
            b_msb_q    <= b_msb_d;
            overflow_q <= overflow_d;
`endif
        end
    end

    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);
    assign diff   = diff_q;
    assign borrow = borrow_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
    assign overflow = overflow_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8) against an arithmetic reference model.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic         overflow;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] prev_diff   = '0;
    logic         prev_borrow = 1'b0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a_i),
        .b        (b_i),
        .busy     (busy),
        .done     (done),
        .diff     (diff),
`ifdef SERIAL_SUB_OVERFLOW_EN
        .overflow (overflow),
`endif
        .borrow   (borrow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on the unsigned and signed interpretations.
    function automatic logic [W-1:0] model_diff(input logic [W-1:0] x, input logic [W-1:0] y);
        int r;
        r = int'(x) - int'(y);
        if (r < 0) r = r + (1 << W);
        return r[W-1:0];
    endfunction

    function automatic logic model_borrow(input logic [W-1:0] x, input logic [W-1:0] y);
        return int'(x) < int'(y);
    endfunction

    function automatic logic model_ovf(input logic [W-1:0] x, input logic [W-1:0] y);
        int sx, sy, r;
        sx = (int'(x) >= (1 << (W-1))) ? int'(x) - (1 << W) : int'(x);
        sy = (int'(y) >= (1 << (W-1))) ? int'(y) - (1 << W) : int'(y);
        r  = sx - sy;
        return (r > (1 << (W-1)) - 1) || (r < -(1 << (W-1)));
    endfunction

    // One full operation; assumes the DUT is (or will be, next cycle) in IDLE.
    task automatic do_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b);
        logic [W-1:0] ed;
        logic         eb;
        ed = model_diff(op_a, op_b);
        eb = model_borrow(op_a, op_b);
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_before_start: busy=%b done=%b, required busy=0 done=0", busy, done);
        end
        a_i = op_a; b_i = op_b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a_i = W'($urandom); b_i = W'($urandom);
        for (int k = 1; k <= W; k++) begin
            n_tests++;
            if (busy !== 1'b1 || done !== 1'b0 || diff !== prev_diff || borrow !== prev_borrow) begin
                n_fail++;
                $display("FAIL run_cycle%0d a=%h b=%h: busy=%b done=%b diff=%h borrow=%b, required busy=1 done=0 diff=%h borrow=%b",
                         k, op_a, op_b, busy, done, diff, borrow, prev_diff, prev_borrow);
            end
            @(negedge clk);
        end
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b1 || diff !== ed || borrow !== eb) begin
            n_fail++;
            $display("FAIL result a=%h b=%h: busy=%b done=%b diff=%h borrow=%b, required busy=0 done=1 diff=%h borrow=%b",
                     op_a, op_b, busy, done, diff, borrow, ed, eb);
        end
`ifdef SERIAL_SUB_OVERFLOW_EN
        n_tests++;
        if (overflow !== model_ovf(op_a, op_b)) begin
            n_fail++;
            $display("FAIL overflow a=%h b=%h: got %b, required %b", op_a, op_b, overflow, model_ovf(op_a, op_b));
        end
`endif
        prev_diff   = ed;
        prev_borrow = eb;
    endtask

    task automatic check_zero(input string name);
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || diff !== '0 || borrow !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: busy=%b done=%b diff=%h borrow=%b, required all 0", name, busy, done, diff, borrow);
        end
`ifdef SERIAL_SUB_OVERFLOW_EN
        n_tests++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_overflow: got %b, required 0", name, overflow);
        end
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a_i = '0; b_i = '0;
        repeat (3) @(negedge clk);
        check_zero("reset_state");
        // rst and start together: start must be dropped
        a_i = 8'h33; b_i = 8'h11; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check_zero("rst_wins_over_start");
        @(negedge clk);
        check_zero("rst_start_no_run");
        prev_diff = '0; prev_borrow = 1'b0;
    endtask

    task automatic test_directed();
        do_op(8'h05, 8'h03);
        do_op(8'h03, 8'h05);
        do_op(8'h00, 8'hFF);
        do_op(8'hAA, 8'hAA);
        do_op(8'h80, 8'h01);
        do_op(8'h7F, 8'h01);
        do_op(8'hFF, 8'h00);
    endtask

    task automatic test_start_held();
        logic [W-1:0] x1, y1, x2, y2;
        x1 = W'($urandom); y1 = W'($urandom);
        x2 = W'($urandom); y2 = W'($urandom);
        @(negedge clk);
        a_i = x1; b_i = y1; start = 1'b1;
        for (int k = 1; k <= W; k++) begin
            @(negedge clk);
            if (k == 3) begin a_i = x2; b_i = y2; end
            n_tests++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL held_first_run%0d: busy=%b done=%b, required busy=1 done=0", k, busy, done);
            end
        end
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b1 || diff !== model_diff(x1, y1) || borrow !== model_borrow(x1, y1)) begin
            n_fail++;
            $display("FAIL held_first_result: busy=%b done=%b diff=%h borrow=%b, required busy=0 done=1 diff=%h borrow=%b",
                     busy, done, diff, borrow, model_diff(x1, y1), model_borrow(x1, y1));
        end
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL held_idle_gap: busy=%b done=%b, required busy=0 done=0", busy, done);
        end
        for (int k = 1; k <= W; k++) begin
            @(negedge clk);
            n_tests++;
            if (busy !== 1'b1 || done !== 1'b0 || diff !== model_diff(x1, y1)) begin
                n_fail++;
                $display("FAIL held_second_run%0d: busy=%b done=%b diff=%h, required busy=1 done=0 diff=%h",
                         k, busy, done, diff, model_diff(x1, y1));
            end
        end
        start = 1'b0;
        @(negedge clk);
        n_tests++;
        if (done !== 1'b1 || diff !== model_diff(x2, y2) || borrow !== model_borrow(x2, y2)) begin
            n_fail++;
            $display("FAIL held_second_result: done=%b diff=%h borrow=%b, required done=1 diff=%h borrow=%b",
                     done, diff, borrow, model_diff(x2, y2), model_borrow(x2, y2));
        end
        prev_diff   = model_diff(x2, y2);
        prev_borrow = model_borrow(x2, y2);
    endtask

    task automatic test_mid_run_reset();
        int dones;
        @(negedge clk);
        a_i = 8'h10; b_i = 8'h01; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // negedge k precedes the edge that processes bit k-1; assert rst ahead of bit 4
        for (int k = 1; k < 5; k++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_zero("mid_run_reset");
        dones = 0;
        for (int k = 0; k < W + 2; k++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) dones++;
        end
        n_tests++;
        if (dones != 0) begin
            n_fail++;
            $display("FAIL abort_no_done: saw %0d busy/done cycles, required 0", dones);
        end
        prev_diff = '0; prev_borrow = 1'b0;
        do_op(8'h10, 8'h01);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 12; i++) do_op(W'($urandom), W'($urandom));
    endtask

    task automatic test_random_gaps();
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            do_op(W'($urandom), W'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_start_held();
        test_mid_run_reset();
        test_back_to_back();
        test_random_gaps();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor computing diff = a - b LSB-first, one bit per clock.
- Built around a single half/full-subtractor bit cell plus a registered borrow flip-flop.
- Sequential inverse companion to the lab's adder datapath; uses a start/done handshake so a bench or controller can drive it.
- Sits between a stimulus source (switches or a bench) and result display/checking logic.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range WIDTH >= 2.

Ports:
- clk  input  1  single system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to begin a subtraction; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on the accepting edge.
- b  input  WIDTH  subtrahend; captured on the accepting edge.
- busy  output  1  high while a subtraction is in progress (RUN state).
- done  output  1  one-cycle pulse; diff/borrow are valid from this cycle onward.
- diff  output  WIDTH  registered result, a - b modulo 2^WIDTH.
- borrow  output  1  registered final borrow-out; 1 iff unsigned a < b.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). No asynchronous logic.
- Reset values: state=IDLE, busy=0, done=0, diff=0, borrow=0, internal shift registers, borrow flip-flop and bit counter all 0.
- States:
  - IDLE: busy=0, done=0. On start=1 at an edge:
    - capture a and b into shift registers sa and sb;
    - clear the borrow flip-flop bf and the counter cnt;
    - go to RUN.
  - RUN: busy=1. Each edge:
    - d = sa[0] ^ sb[0] ^ bf;
    - bf <= (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & bf);
    - shift d into the result shift register from the MSB side;
    - shift sa and sb right by 1;
    - cnt <= cnt + 1.
    - On the edge that processes bit WIDTH-1 (cnt = WIDTH-1): load diff from the completed result and borrow from the new bf, then go to DONE.
  - DONE: busy=0, done=1 for exactly one cycle. Next edge unconditionally returns to IDLE.
- Latency: start accepted at edge E0. Bit i is processed at edge E0+1+i. done is high during the cycle after edge E0+WIDTH. Total start-to-done is WIDTH+1 edges. Throughput: one operation per WIDTH+2 cycles.
- start while busy=1 or done=1 is ignored, with no queuing. a/b changes after capture have no effect on the operation in progress.
- diff and borrow hold their last values until the next completion. They do not change during RUN.
- Counter width is clog2(WIDTH)+1 bits; no wrap before the terminal count.
- Reset asserted in any state, including mid-RUN: next edge forces the full reset values and aborts the operation. No done pulse is produced.
- Simultaneous rst and start: rst wins and start is dropped.

Optional Feature:
- Macro SERIAL_SUB_OVERFLOW_EN.
- When defined:
  - adds output port overflow (1 bit, reset 0, registered alongside diff);
  - overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]), using the captured operands, i.e. signed two's-complement overflow;
  - updated only at completion.
- When not defined: the port and its logic do not exist; all other behaviour is identical.

Test Plan:
- WIDTH=8, a=5, b=3, start pulsed 1 cycle from IDLE -> busy high 8 cycles, done pulse on the 9th cycle after the accepting edge, diff=0x02, borrow=0.
- a=3, b=5 -> diff=0xFE, borrow=1. Then a=0x00, b=0xFF -> diff=0x01, borrow=1. Then a=0xAA, b=0xAA -> diff=0x00, borrow=0.
- start held high continuously with operands changed mid-RUN -> the first capture completes with the original result, done pulses once, busy stays low in DONE, and the next operation starts from IDLE using the operands present then.
- rst asserted for 1 cycle at bit 4 of a=0x10, b=0x01 -> all outputs 0 on the following cycle, no done pulse. A new start then completes normally with diff=0x0F.
- With SERIAL_SUB_OVERFLOW_EN: a=0x80, b=0x01 -> diff=0x7F, borrow=0, overflow=1. a=0x7F, b=0x01 -> diff=0x7E, overflow=0.
- Back-to-back operations, each starting in the first IDLE cycle after done -> results correct and diff stable between completions.
